// File: rtl/cva6_shared_tlb_sv32_pkg.sv
//------------------------------------------------------------------------------
// Module : cva6_shared_tlb_sv32_pkg
// Brief  : Sv32 shared-TLB types: PTE, L1/walker update record, TLB entry,
//          lookup FSM states and the Sv32 VPN match helper.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cva6_shared_tlb_sv32_pkg;

    localparam int unsigned VLEN       = 32;
    // Widest Sv32 ASID; narrower configurations keep the upper bits zero.
    localparam int unsigned ASID_W_MAX = 9;

    typedef struct packed {
        logic [21:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_sv32_t;

    typedef struct packed {
        logic                  valid;
        logic                  is_4M;
        logic [19:0]           vpn;
        logic [ASID_W_MAX-1:0] asid;
        pte_sv32_t             content;
    } tlb_update_sv32_t;

    typedef struct packed {
        logic                  valid;
        logic                  is_4M;
        logic [19:0]           vpn;
        logic [ASID_W_MAX-1:0] asid;
        pte_sv32_t             content;
    } shared_tlb_entry_sv32_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOOKUP = 1'b1
    } shared_tlb_state_e;

    // A 4 MiB superpage only compares VPN[1]; a 4 KiB page compares both levels.
    function automatic logic sv32_vpn_match(input logic        is_4M,
                                            input logic [19:0] entry_vpn,
                                            input logic [19:0] req_vpn);
        return (entry_vpn[19:10] == req_vpn[19:10]) &&
               (is_4M || (entry_vpn[9:0] == req_vpn[9:0]));
    endfunction

endpackage

`default_nettype wire

// File: rtl/cva6_shared_tlb_sv32_repl.sv
//------------------------------------------------------------------------------
// Module : cva6_shared_tlb_sv32_repl
// Brief  : Victim index generation for the shared TLB. The lowest invalid
//          entry is always preferred; otherwise a round-robin pointer is used,
//          or a tree pseudo-LRU when CVA6_SHARED_TLB_PLRU_EN is defined.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cva6_shared_tlb_sv32_repl #(
    parameter  int unsigned ENTRIES = 16,
    localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               hit_valid_i,
    input  logic [IDX_W-1:0]   hit_idx_i,
    input  logic               fill_valid_i,
    input  logic [ENTRIES-1:0] valid_i,
    output logic [IDX_W-1:0]   victim_idx_o
);

    logic             has_invalid;
    logic [IDX_W-1:0] invalid_idx;
    logic [IDX_W-1:0] repl_idx;

    // Lowest-numbered invalid entry (scan downward so the lowest wins).
    always_comb begin
        has_invalid = 1'b0;
        invalid_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                has_invalid = 1'b1;
                invalid_idx = IDX_W'(i);
            end
        end
    end

    assign victim_idx_o = has_invalid ? invalid_idx : repl_idx;

`ifdef CVA6_SHARED_TLB_PLRU_EN
    // Binary tree: node n has children 2n+1 (bit 0) and 2n+2 (bit 1); each
    // node bit points toward the subtree that should be evicted next.
    logic [ENTRIES-2:0] tree_q;
    logic [ENTRIES-2:0] tree_d;

    // Follow the tree bits from the root to find the least recently used leaf.
    always_comb begin
        logic [IDX_W-1:0] node;
        logic             b;
        repl_idx = '0;
        node     = '0;
        for (int lvl = 0; lvl < int'(IDX_W); lvl++) begin
            b        = tree_q[node];
            repl_idx = IDX_W'({repl_idx, b});
            node     = IDX_W'((32'(node) << 1) + 32'd1 + 32'(b));
        end
    end

    // Touch the hit entry first, then the filled entry, pointing nodes away.
    always_comb begin
        logic [IDX_W-1:0] node;
        logic [IDX_W-1:0] rem;
        logic             b;
        tree_d = tree_q;
        if (hit_valid_i) begin
            node = '0;
            rem  = hit_idx_i;
            for (int lvl = 0; lvl < int'(IDX_W); lvl++) begin
                b            = rem[IDX_W-1];
                rem          = rem << 1;
                tree_d[node] = ~b;
                node         = IDX_W'((32'(node) << 1) + 32'd1 + 32'(b));
            end
        end
        if (fill_valid_i) begin
            node = '0;
            rem  = victim_idx_o;
            for (int lvl = 0; lvl < int'(IDX_W); lvl++) begin
                b            = rem[IDX_W-1];
                rem          = rem << 1;
                tree_d[node] = ~b;
                node         = IDX_W'((32'(node) << 1) + 32'd1 + 32'(b));
            end
        end
    end

    // PLRU tree state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tree_q <= '0;
        end else begin
            tree_q <= tree_d;
        end
    end
`else
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             unused_hit;

    // Hits do not influence round-robin replacement.
    assign unused_hit = ^{hit_valid_i, hit_idx_i};
    assign repl_idx   = ptr_q;

    // Pointer advances on every fill; power-of-two size makes the wrap free.
    always_comb begin
        ptr_d = ptr_q;
        if (fill_valid_i) begin
            ptr_d = ptr_q + IDX_W'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/cva6_shared_tlb_sv32.sv
//------------------------------------------------------------------------------
// Module : cva6_shared_tlb_sv32
// Brief  : Fully-associative Sv32 second-level TLB shared by ITLB and DTLB.
//          Accepts one L1 miss at a time (ITLB first), looks it up the next
//          cycle, refills the L1 on a hit, and absorbs/forwards walker fills.
//          Define CVA6_SHARED_TLB_PLRU_EN for pseudo-LRU replacement.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cva6_shared_tlb_sv32
    import cva6_shared_tlb_sv32_pkg::*;
#(
    parameter int unsigned SHARED_TLB_ENTRIES = 16,
    parameter int unsigned ASID_WIDTH         = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  enable_translation_i,
    input  logic                  en_ld_st_translation_i,
    input  logic [ASID_WIDTH-1:0] asid_i,
    input  logic                  itlb_access_i,
    input  logic                  itlb_hit_i,
    input  logic [VLEN-1:0]       itlb_vaddr_i,
    input  logic                  dtlb_access_i,
    input  logic                  dtlb_hit_i,
    input  logic [VLEN-1:0]       dtlb_vaddr_i,
    output tlb_update_sv32_t      itlb_update_o,
    output tlb_update_sv32_t      dtlb_update_o,
    output logic                  itlb_miss_o,
    output logic                  dtlb_miss_o,
    output logic                  shared_tlb_access_o,
    output logic                  shared_tlb_hit_o,
    output logic [VLEN-1:0]       shared_tlb_vaddr_o,
    output logic                  itlb_req_o,
    input  logic                  ptw_active_i,
    input  logic                  walking_instr_i,
    input  tlb_update_sv32_t      shared_tlb_update_i
);

    localparam int unsigned SHARED_TLB_IDX_W = $clog2(SHARED_TLB_ENTRIES);

    shared_tlb_state_e      state_q, state_d;
    logic [VLEN-1:0]        vaddr_q, vaddr_d;
    logic                   is_instr_q, is_instr_d;
    shared_tlb_entry_sv32_t entries_q [SHARED_TLB_ENTRIES];

    logic [SHARED_TLB_ENTRIES-1:0] match;
    logic [SHARED_TLB_ENTRIES-1:0] valid_vec;
    logic                          any_match;
    logic [SHARED_TLB_IDX_W-1:0]   hit_idx;
    logic [SHARED_TLB_IDX_W-1:0]   victim_idx;
    logic                          lookup_act;
    logic                          lookup_hit;
    logic                          fill_valid;
    logic                          itlb_new;
    logic                          dtlb_new;
    tlb_update_sv32_t              hit_update;

    // Tag compare against every entry; lowest matching index is selected.
    always_comb begin
        match     = '0;
        valid_vec = '0;
        any_match = 1'b0;
        hit_idx   = '0;
        for (int i = SHARED_TLB_ENTRIES - 1; i >= 0; i--) begin
            valid_vec[i] = entries_q[i].valid;
            match[i]     = entries_q[i].valid &&
                           ((entries_q[i].asid == ASID_W_MAX'(asid_i)) ||
                            entries_q[i].content.g) &&
                           sv32_vpn_match(entries_q[i].is_4M, entries_q[i].vpn,
                                          vaddr_q[31:12]);
            if (match[i]) begin
                any_match = 1'b1;
                hit_idx   = SHARED_TLB_IDX_W'(i);
            end
        end
    end

    assign itlb_new   = !rst_i && enable_translation_i && itlb_access_i &&
                        !itlb_hit_i && !ptw_active_i;
    assign dtlb_new   = !rst_i && en_ld_st_translation_i && dtlb_access_i &&
                        !dtlb_hit_i && !ptw_active_i;
    assign lookup_act = !rst_i && (state_q == LOOKUP) && !flush_i;
    assign lookup_hit = lookup_act && any_match;
    assign fill_valid = !rst_i && shared_tlb_update_i.valid && !flush_i;

    assign shared_tlb_access_o = lookup_act;
    assign shared_tlb_hit_o    = lookup_hit;
    assign shared_tlb_vaddr_o  = lookup_act ? vaddr_q : '0;
    assign itlb_req_o          = lookup_act && is_instr_q;

    // Refill record built from the hit entry, tagged with the current ASID.
    always_comb begin
        hit_update         = '0;
        hit_update.valid   = 1'b1;
        hit_update.is_4M   = entries_q[hit_idx].is_4M;
        hit_update.vpn     = entries_q[hit_idx].vpn;
        hit_update.asid    = ASID_W_MAX'(asid_i);
        hit_update.content = entries_q[hit_idx].content;
    end

    // L1 refill ports: a walker fill takes priority over a lookup hit.
    always_comb begin
        itlb_update_o = '0;
        dtlb_update_o = '0;
        if (lookup_hit && is_instr_q) begin
            itlb_update_o = hit_update;
        end
        if (lookup_hit && !is_instr_q) begin
            dtlb_update_o = hit_update;
        end
        if (fill_valid && walking_instr_i) begin
            itlb_update_o = shared_tlb_update_i;
        end
        if (fill_valid && !walking_instr_i) begin
            dtlb_update_o = shared_tlb_update_i;
        end
    end

    // Miss acceptance and lookup sequencing; ITLB wins simultaneous misses.
    always_comb begin
        state_d     = state_q;
        vaddr_d     = vaddr_q;
        is_instr_d  = is_instr_q;
        itlb_miss_o = 1'b0;
        dtlb_miss_o = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (itlb_new) begin
                        itlb_miss_o = 1'b1;
                        vaddr_d     = itlb_vaddr_i;
                        is_instr_d  = 1'b1;
                        state_d     = LOOKUP;
                    end else if (dtlb_new) begin
                        dtlb_miss_o = 1'b1;
                        vaddr_d     = dtlb_vaddr_i;
                        is_instr_d  = 1'b0;
                        state_d     = LOOKUP;
                    end
                end
                LOOKUP:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM and latched request registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            vaddr_q    <= '0;
            is_instr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vaddr_q    <= vaddr_d;
            is_instr_q <= is_instr_d;
        end
    end

    // Entry storage: flush invalidates everything and overrides any fill.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(SHARED_TLB_ENTRIES); i++) begin
                entries_q[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < int'(SHARED_TLB_ENTRIES); i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else if (fill_valid) begin
            entries_q[victim_idx].valid   <= 1'b1;
            entries_q[victim_idx].is_4M   <= shared_tlb_update_i.is_4M;
            entries_q[victim_idx].vpn     <= shared_tlb_update_i.vpn;
            entries_q[victim_idx].asid    <= shared_tlb_update_i.asid;
            entries_q[victim_idx].content <= shared_tlb_update_i.content;
        end
    end

    cva6_shared_tlb_sv32_repl #(
        .ENTRIES (SHARED_TLB_ENTRIES)
    ) u_repl (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .hit_valid_i  (lookup_hit),
        .hit_idx_i    (hit_idx),
        .fill_valid_i (fill_valid),
        .valid_i      (valid_vec),
        .victim_idx_o (victim_idx)
    );

endmodule

`default_nettype wire

// File: tb/tb_cva6_shared_tlb_sv32.sv
//------------------------------------------------------------------------------
// Module : tb_cva6_shared_tlb_sv32
// Brief  : Self-checking bench for the shared Sv32 TLB: table of fills and
//          lookups, then hand-written arbitration, reset, capacity, fill-vs-
//          hit and flush sequences.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cva6_shared_tlb_sv32;
    import cva6_shared_tlb_sv32_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             flush_i = 1'b0;
    logic             enable_translation_i = 1'b1;
    logic             en_ld_st_translation_i = 1'b1;
    logic [0:0]       asid_i = '0;
    logic             itlb_access_i = 1'b0;
    logic             itlb_hit_i = 1'b0;
    logic [31:0]      itlb_vaddr_i = '0;
    logic             dtlb_access_i = 1'b0;
    logic             dtlb_hit_i = 1'b0;
    logic [31:0]      dtlb_vaddr_i = '0;
    tlb_update_sv32_t itlb_update_o;
    tlb_update_sv32_t dtlb_update_o;
    logic             itlb_miss_o;
    logic             dtlb_miss_o;
    logic             shared_tlb_access_o;
    logic             shared_tlb_hit_o;
    logic [31:0]      shared_tlb_vaddr_o;
    logic             itlb_req_o;
    logic             ptw_active_i = 1'b0;
    logic             walking_instr_i = 1'b0;
    tlb_update_sv32_t shared_tlb_update_i = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    cva6_shared_tlb_sv32 #(
        .SHARED_TLB_ENTRIES (16),
        .ASID_WIDTH         (1)
    ) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .flush_i                (flush_i),
        .enable_translation_i   (enable_translation_i),
        .en_ld_st_translation_i (en_ld_st_translation_i),
        .asid_i                 (asid_i),
        .itlb_access_i          (itlb_access_i),
        .itlb_hit_i             (itlb_hit_i),
        .itlb_vaddr_i           (itlb_vaddr_i),
        .dtlb_access_i          (dtlb_access_i),
        .dtlb_hit_i             (dtlb_hit_i),
        .dtlb_vaddr_i           (dtlb_vaddr_i),
        .itlb_update_o          (itlb_update_o),
        .dtlb_update_o          (dtlb_update_o),
        .itlb_miss_o            (itlb_miss_o),
        .dtlb_miss_o            (dtlb_miss_o),
        .shared_tlb_access_o    (shared_tlb_access_o),
        .shared_tlb_hit_o       (shared_tlb_hit_o),
        .shared_tlb_vaddr_o     (shared_tlb_vaddr_o),
        .itlb_req_o             (itlb_req_o),
        .ptw_active_i           (ptw_active_i),
        .walking_instr_i        (walking_instr_i),
        .shared_tlb_update_i    (shared_tlb_update_i)
    );

    typedef struct {
        logic        is_fill;
        logic        instr;
        logic [31:0] vaddr;
        logic        is4m;
        logic        g;
        logic        asid;
        logic [21:0] ppn;
        logic        exp_hit;
    } vec_t;

    vec_t vec [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic pte_sv32_t mk_pte(input logic [21:0] ppn, input logic g);
        pte_sv32_t p;
        p     = '0;
        p.ppn = ppn;
        p.d   = 1'b1;
        p.a   = 1'b1;
        p.g   = g;
        p.x   = 1'b1;
        p.w   = 1'b1;
        p.r   = 1'b1;
        p.v   = 1'b1;
        return p;
    endfunction

    function automatic tlb_update_sv32_t mk_upd(input logic [31:0] va, input logic is4m,
                                                input logic g, input logic asid,
                                                input logic [21:0] ppn);
        tlb_update_sv32_t u;
        u         = '0;
        u.valid   = 1'b1;
        u.is_4M   = is4m;
        u.vpn     = va[31:12];
        u.asid    = 9'(asid);
        u.content = mk_pte(ppn, g);
        return u;
    endfunction

    // Walker fill in IDLE; checks it is forwarded to exactly the walking L1.
    task automatic do_fill(input string nm, input logic instr, input logic [31:0] va,
                           input logic is4m, input logic g, input logic asid,
                           input logic [21:0] ppn);
        @(negedge clk_i);
        shared_tlb_update_i = mk_upd(va, is4m, g, asid, ppn);
        walking_instr_i     = instr;
        #1;
        if (instr) begin
            chk({nm, "_fwd_i_valid"}, 64'(itlb_update_o.valid), 64'd1);
            chk({nm, "_fwd_i_ppn"}, 64'(itlb_update_o.content.ppn), 64'(ppn));
            chk({nm, "_fwd_d_valid"}, 64'(dtlb_update_o.valid), 64'd0);
        end else begin
            chk({nm, "_fwd_d_valid"}, 64'(dtlb_update_o.valid), 64'd1);
            chk({nm, "_fwd_d_ppn"}, 64'(dtlb_update_o.content.ppn), 64'(ppn));
            chk({nm, "_fwd_i_valid"}, 64'(itlb_update_o.valid), 64'd0);
        end
        @(posedge clk_i);
        #1;
        shared_tlb_update_i = '0;
        walking_instr_i     = 1'b0;
    endtask

    // One L1 miss: acceptance cycle, then the LOOKUP cycle outputs.
    task automatic do_lookup(input string nm, input logic instr, input logic [31:0] va,
                             input logic asid, input logic exp_hit, input logic [21:0] ppn);
        @(negedge clk_i);
        asid_i = asid;
        if (instr) begin
            itlb_access_i = 1'b1;
            itlb_vaddr_i  = va;
        end else begin
            dtlb_access_i = 1'b1;
            dtlb_vaddr_i  = va;
        end
        #1;
        chk({nm, "_miss_o"}, 64'(instr ? itlb_miss_o : dtlb_miss_o), 64'd1);
        @(posedge clk_i);
        #1;
        itlb_access_i = 1'b0;
        dtlb_access_i = 1'b0;
        chk({nm, "_access"}, 64'(shared_tlb_access_o), 64'd1);
        chk({nm, "_vaddr"}, 64'(shared_tlb_vaddr_o), 64'(va));
        chk({nm, "_itlb_req"}, 64'(itlb_req_o), 64'(instr));
        chk({nm, "_hit"}, 64'(shared_tlb_hit_o), 64'(exp_hit));
        if (instr) begin
            chk({nm, "_upd_valid"}, 64'(itlb_update_o.valid), 64'(exp_hit));
            chk({nm, "_other_valid"}, 64'(dtlb_update_o.valid), 64'd0);
            if (exp_hit) chk({nm, "_upd_ppn"}, 64'(itlb_update_o.content.ppn), 64'(ppn));
        end else begin
            chk({nm, "_upd_valid"}, 64'(dtlb_update_o.valid), 64'(exp_hit));
            chk({nm, "_other_valid"}, 64'(itlb_update_o.valid), 64'd0);
            if (exp_hit) chk({nm, "_upd_ppn"}, 64'(dtlb_update_o.content.ppn), 64'(ppn));
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                is_fill instr vaddr          4M  g   asid ppn        hit
        vec[0] = '{1'b0, 1'b1, 32'h4000_1000, 1'b0, 1'b0, 1'b0, 22'h0,     1'b0};
        vec[1] = '{1'b1, 1'b0, 32'h4000_1000, 1'b1, 1'b0, 1'b0, 22'h12345, 1'b0};
        vec[2] = '{1'b0, 1'b0, 32'h4003_F000, 1'b0, 1'b0, 1'b0, 22'h12345, 1'b1};
        vec[3] = '{1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 22'h00111, 1'b0};
        vec[4] = '{1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 22'h00111, 1'b1};
        vec[5] = '{1'b1, 1'b0, 32'h9000_0000, 1'b0, 1'b0, 1'b0, 22'h00222, 1'b0};
        vec[6] = '{1'b0, 1'b0, 32'h9000_0000, 1'b0, 1'b0, 1'b1, 22'h0,     1'b0};
        vec[7] = '{1'b0, 1'b0, 32'h9000_0000, 1'b0, 1'b0, 1'b0, 22'h00222, 1'b1};
        vec[8] = '{1'b0, 1'b1, 32'h8000_1000, 1'b0, 1'b0, 1'b0, 22'h0,     1'b0};

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_access", 64'(shared_tlb_access_o), 64'd0);
        chk("rst_hit", 64'(shared_tlb_hit_o), 64'd0);
        chk("rst_vaddr", 64'(shared_tlb_vaddr_o), 64'd0);
        chk("rst_itlb_req", 64'(itlb_req_o), 64'd0);
        chk("rst_iupd", 64'(itlb_update_o.valid), 64'd0);
        chk("rst_dupd", 64'(dtlb_update_o.valid), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Table: empty miss, 4M superpage hit, global/ASID matching
        for (int i = 0; i < 9; i++) begin
            if (vec[i].is_fill)
                do_fill($sformatf("v%0d", i), vec[i].instr, vec[i].vaddr, vec[i].is4m,
                        vec[i].g, vec[i].asid, vec[i].ppn);
            else
                do_lookup($sformatf("v%0d", i), vec[i].instr, vec[i].vaddr, vec[i].asid,
                          vec[i].exp_hit, vec[i].ppn);
        end
        asid_i = 1'b0;

        // Simultaneous ITLB and DTLB misses: ITLB first, DTLB on re-presentation
        @(negedge clk_i);
        itlb_access_i = 1'b1; itlb_vaddr_i = 32'h5000_0000;
        dtlb_access_i = 1'b1; dtlb_vaddr_i = 32'h6000_0000;
        #1;
        chk("both_itlb_miss", 64'(itlb_miss_o), 64'd1);
        chk("both_dtlb_miss", 64'(dtlb_miss_o), 64'd0);
        @(posedge clk_i);
        #1;
        itlb_access_i = 1'b0;
        chk("both_lk1_access", 64'(shared_tlb_access_o), 64'd1);
        chk("both_lk1_req", 64'(itlb_req_o), 64'd1);
        chk("both_lk1_vaddr", 64'(shared_tlb_vaddr_o), 64'h5000_0000);
        chk("both_lk1_dmiss", 64'(dtlb_miss_o), 64'd0);
        @(posedge clk_i);
        #1;
        chk("both_retry_dmiss", 64'(dtlb_miss_o), 64'd1);
        @(posedge clk_i);
        #1;
        dtlb_access_i = 1'b0;
        chk("both_lk2_access", 64'(shared_tlb_access_o), 64'd1);
        chk("both_lk2_req", 64'(itlb_req_o), 64'd0);
        chk("both_lk2_vaddr", 64'(shared_tlb_vaddr_o), 64'h6000_0000);
        @(posedge clk_i);
        #1;

        // Walker busy blocks acceptance
        @(negedge clk_i);
        ptw_active_i = 1'b1; itlb_access_i = 1'b1; itlb_vaddr_i = 32'h5000_0000;
        #1;
        chk("ptw_busy_miss", 64'(itlb_miss_o), 64'd0);
        @(posedge clk_i);
        #1;
        chk("ptw_busy_access", 64'(shared_tlb_access_o), 64'd0);
        itlb_access_i = 1'b0; ptw_active_i = 1'b0;

        // Reset asserted mid-LOOKUP with a fill pending
        @(negedge clk_i);
        itlb_access_i = 1'b1; itlb_vaddr_i = 32'h8000_0000;
        @(posedge clk_i);
        #1;
        itlb_access_i = 1'b0;
        chk("rstmid_pre_hit", 64'(shared_tlb_hit_o), 64'd1);
        shared_tlb_update_i = mk_upd(32'h7000_0000, 1'b0, 1'b0, 1'b0, 22'h00777);
        rst_i = 1'b1;
        #1;
        chk("rstmid_access", 64'(shared_tlb_access_o), 64'd0);
        chk("rstmid_iupd", 64'(itlb_update_o.valid), 64'd0);
        chk("rstmid_dupd", 64'(dtlb_update_o.valid), 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        shared_tlb_update_i = '0;
        do_lookup("rstmid_cleared", 1'b1, 32'h8000_0000, 1'b0, 1'b0, 22'h0);
        do_lookup("rstmid_nofill", 1'b0, 32'h7000_0000, 1'b0, 1'b0, 22'h0);

        // Capacity: 17 distinct 4K pages into 16 entries evicts the first
        for (int k = 0; k < 17; k++) begin
            do_fill($sformatf("cap%0d", k), 1'b0, 32'h1000_0000 + (k << 12), 1'b0, 1'b0,
                    1'b0, 22'(k + 1));
        end
        do_lookup("cap_p0", 1'b0, 32'h1000_0000, 1'b0, 1'b0, 22'h0);
        do_lookup("cap_p1", 1'b0, 32'h1000_1000, 1'b0, 1'b1, 22'h2);
        do_lookup("cap_p16", 1'b1, 32'h1001_0000, 1'b0, 1'b1, 22'h11);

        // Lookup hit and fill to the same L1 in one cycle: the fill wins
        @(negedge clk_i);
        itlb_access_i = 1'b1; itlb_vaddr_i = 32'h1000_1000;
        @(posedge clk_i);
        #1;
        itlb_access_i = 1'b0;
        shared_tlb_update_i = mk_upd(32'h2000_0000, 1'b0, 1'b0, 1'b0, 22'h00777);
        walking_instr_i = 1'b1;
        #1;
        chk("collide_hit", 64'(shared_tlb_hit_o), 64'd1);
        chk("collide_iupd_valid", 64'(itlb_update_o.valid), 64'd1);
        chk("collide_iupd_ppn", 64'(itlb_update_o.content.ppn), 64'h777);
        chk("collide_iupd_vpn", 64'(itlb_update_o.vpn), 64'h20000);
        chk("collide_dupd", 64'(dtlb_update_o.valid), 64'd0);
        @(posedge clk_i);
        #1;
        shared_tlb_update_i = '0; walking_instr_i = 1'b0;

        // Flush concurrent with a fill and a LOOKUP hit
        @(negedge clk_i);
        dtlb_access_i = 1'b1; dtlb_vaddr_i = 32'h1001_0000;
        @(posedge clk_i);
        #1;
        dtlb_access_i = 1'b0;
        flush_i = 1'b1;
        shared_tlb_update_i = mk_upd(32'h3000_0000, 1'b0, 1'b0, 1'b0, 22'h00888);
        #1;
        chk("flush_access", 64'(shared_tlb_access_o), 64'd0);
        chk("flush_hit", 64'(shared_tlb_hit_o), 64'd0);
        chk("flush_dupd", 64'(dtlb_update_o.valid), 64'd0);
        chk("flush_iupd", 64'(itlb_update_o.valid), 64'd0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        shared_tlb_update_i = '0;
        do_lookup("flush_p16", 1'b0, 32'h1001_0000, 1'b0, 1'b0, 22'h0);
        do_lookup("flush_fill", 1'b0, 32'h3000_0000, 1'b0, 1'b0, 22'h0);
        do_lookup("flush_prev", 1'b1, 32'h2000_0000, 1'b0, 1'b0, 22'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cva6_shared_tlb_sv32.md
Name: cva6_shared_tlb_sv32

Overview:
- Second-level, fully-associative Sv32 TLB shared by the ITLB and DTLB.
- Arbitrates L1 TLB misses, looks them up, and on a hit refills the requesting L1 TLB.
- On a miss, presents the request to the Sv32 page-table walker: shared_tlb_access/hit/vaddr, itlb_req.
- Consumes the walker's tlb_update_sv32_t to fill itself and forwards that update to the L1 TLB that missed.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration.
- SHARED_TLB_ENTRIES, 16, entry count; power of two, 2..64.
- ASID_WIDTH, 1, ASID width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- flush_i  in  1  invalidate all entries, abort lookup
- enable_translation_i  in  1  instruction translation on
- en_ld_st_translation_i  in  1  data translation on
- asid_i  in  ASID_WIDTH  current ASID
- itlb_access_i / itlb_hit_i  in  1 / 1  ITLB lookup, ITLB hit
- itlb_vaddr_i  in  VLEN  ITLB vaddr
- dtlb_access_i / dtlb_hit_i  in  1 / 1  DTLB lookup, DTLB hit
- dtlb_vaddr_i  in  VLEN  DTLB vaddr
- itlb_update_o / dtlb_update_o  out  tlb_update_sv32_t  L1 refill
- itlb_miss_o / dtlb_miss_o  out  1  L1 miss accepted (perf)
- shared_tlb_access_o  out  1  lookup result valid (to PTW)
- shared_tlb_hit_o  out  1  lookup hit
- shared_tlb_vaddr_o  out  VLEN  looked-up vaddr
- itlb_req_o  out  1  lookup on behalf of ITLB
- ptw_active_i  in  1  walker busy
- walking_instr_i  in  1  walker serving ITLB
- shared_tlb_update_i  in  tlb_update_sv32_t  walker fill

Behaviour:
- Reset: all outputs 0; all entries invalid; state IDLE; replacement pointer 0.
- Entry contents: valid, is_4M, vpn[19:0], asid, content (pte_sv32_t; g = content bit 5).
- Match condition: valid && (asid == asid_i || g) && vpn[19:10] equal && (is_4M || vpn[9:0] equal).
- IDLE, new ITLB miss: enable_translation_i && itlb_access_i && !itlb_hit_i && !ptw_active_i.
  - Latch vaddr; is_instr=1; itlb_miss_o=1 this cycle; go LOOKUP.
- IDLE, new DTLB miss: same rule using en_ld_st_translation_i and the dtlb_* inputs.
  - Latch vaddr; is_instr=0; dtlb_miss_o=1; go LOOKUP.
  - When both miss in the same cycle, ITLB wins; the DTLB re-presents its miss later.
- LOOKUP (exactly 1 cycle after acceptance):
  - shared_tlb_access_o=1, shared_tlb_vaddr_o=latched vaddr, itlb_req_o=is_instr.
  - Hit: shared_tlb_hit_o=1; drive the selected L1 update for one cycle with valid=1, vpn, is_4M, asid=asid_i, content. Replacement state records the hit.
  - Miss: shared_tlb_hit_o=0; the walker starts.
  - Then go IDLE.
  - Multiple matches (illegal): lowest index wins.
- Fill (any state): when shared_tlb_update_i.valid, write the entry at the victim index.
  - Victim = lowest invalid entry, else the replacement pointer. Round-robin default: pointer increments mod SHARED_TLB_ENTRIES on each fill.
  - Same cycle: forward the update unchanged to itlb_update_o if walking_instr_i, else to dtlb_update_o.
  - LOOKUP hit and fill in the same cycle to the same L1: the fill wins the L1 port; the hit refill is dropped (the L1 retries).
- Flush: flush_i clears all valid bits next edge and forces IDLE.
  - In the same cycle, no *_update_o.valid and no shared_tlb_access_o.
  - Flush beats a simultaneous fill.
- No acceptance in IDLE while ptw_active_i=1.
- Reset asserted mid-LOOKUP or mid-fill: immediate return to the reset state; no partial entry is written.

Optional Feature:
- Macro: CVA6_SHARED_TLB_PLRU_EN.
- Defined: tree pseudo-LRU victim selection; lookup hits and fills update the tree. Still applies when no invalid entry exists.
- Undefined: round-robin pointer as above.
- Lowest-invalid-first applies in both builds.

Decomposition:
- ariane_pkg additions: shared_tlb_entry_sv32_t (valid, is_4M, vpn, asid, content) and SHARED_TLB_IDX_W = $clog2(SHARED_TLB_ENTRIES).
- tlb_update_sv32_t is reused.
- One sub-module, cva6_shared_tlb_repl: victim index generation, round-robin or PLRU per macro.
  - Inputs: hit_valid, hit_idx, fill_valid, valid vector.

Test Plan:
- Empty TLB; ITLB miss for vaddr 0x4000_1000 -> next cycle access_o=1, hit_o=0, itlb_req_o=1, vaddr_o=0x4000_1000.
- Fill is_4M=1 vpn 0x40001, walking_instr_i=0; then DTLB miss 0x4003_F000 -> hit_o=1; dtlb_update_o.valid=1 with the fill's content.
- Same-cycle ITLB and DTLB misses -> ITLB served first (itlb_miss_o=1, dtlb_miss_o=0); DTLB accepted on its next presentation.
- Global entry (content bit 5 set) filled under ASID 0, lookup with asid_i=1 -> hit; non-global entry under ASID 1 -> miss.
- Fill 17 distinct 4K pages into 16 entries -> first victim is index 0 (round-robin); the earliest page now misses.
- flush_i concurrent with a fill and a LOOKUP hit -> no update outputs; next lookup of that page misses.
